// File: rtl/lsu_mem_ctrl.sv
// Load/store bus controller: turns one core access into a single req/ack word
// transaction with byte enables, lane-replicated store data and aligned load data.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid,
    input  logic              core_we,
    input  logic [2:0]        core_funct3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic              core_done,
    output logic [31:0]       core_rdata,
    output logic              core_misalign,
    output logic              core_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_e;

    state_e              state_q;
    logic                we_q;
    logic [1:0]          off_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                done_q;
    logic                misalign_q;
    logic                fault_q;
    logic [31:0]         rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [31:0]         mem_wdata_q;

    // Access decode of the live core request, consumed only in IDLE.
    logic        acc_misalign;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;

    always_comb begin
        acc_misalign = 1'b0;
        acc_be       = 4'b1111;
        acc_wdata    = core_wdata;
        case (core_funct3[1:0])
            2'b00: begin
                acc_be    = 4'b0001 << core_addr[1:0];
                acc_wdata = {4{core_wdata[7:0]}};
            end
            2'b01: begin
                acc_be       = 4'b0011 << core_addr[1:0];
                acc_wdata    = {2{core_wdata[15:0]}};
                acc_misalign = core_addr[0];
            end
            2'b10: begin
                acc_misalign = (core_addr[1:0] != 2'b00);
            end
            default: begin
                acc_misalign = 1'b1;
            end
        endcase
        // Unsigned variants exist only for loads, and 110 is never legal.
        if (core_funct3 == 3'b110 || (core_we && core_funct3[2])) begin
            acc_misalign = 1'b1;
        end
        if (!core_we) begin
            acc_be = 4'b1111;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (core_valid) begin
                        we_q        <= core_we;
                        off_q       <= core_addr[1:0];
                        mem_addr_q  <= {core_addr[ADDR_W-1:2], 2'b00};
                        mem_be_q    <= acc_be;
                        mem_wdata_q <= acc_wdata;
                        cnt_q       <= '0;
                        if (acc_misalign) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= core_we;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the final counted cycle still completes cleanly.
                    if (mem_ack) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= mem_rdata >> {off_q, 3'b000};
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        fault_q   <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational in IDLE so the core freezes in the request cycle itself.
    assign core_stall    = !rst && ((state_q == S_IDLE && core_valid) || state_q == S_REQ);
    assign core_done     = done_q;
    assign core_rdata    = rdata_q;
    assign core_misalign = misalign_q;
    assign core_fault    = fault_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomised bench for lsu_mem_ctrl: a per-transaction timeline model drives the
// bus and predicts every output each cycle; directed cases pin the model with literals.
module tb_lsu_mem_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_valid = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_funct3 = 3'b000;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wdata = 32'h0;
    logic        core_stall, core_done, core_misalign, core_fault;
    logic [31:0] core_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_done(core_done), .core_rdata(core_rdata),
        .core_misalign(core_misalign), .core_fault(core_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          w;      // REQ cycle index of the ack; >= TO means never
        logic [31:0] rdata;
    } txn_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int txn_no = 0;
    int start_cyc = 0;

    // Expected outputs for the current cycle
    bit          chk_en = 1'b0;
    logic        e_stall = 0, e_req = 0, e_done = 0, e_mis = 0, e_fault = 0, e_we = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
    logic [3:0]  e_be = 0;

    // Observations used by the literal checks
    int          last_done_cyc = 0;
    int          req_cycles = 0;
    logic        last_mis = 0, last_fault = 0, last_we = 0;
    logic [3:0]  last_be = 0;
    logic [31:0] last_wdata = 0, last_addr = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(core_stall), 32'(e_stall));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("done", 32'(core_done), 32'(e_done));
            chk("misalign", 32'(core_misalign), 32'(e_mis));
            chk("fault", 32'(core_fault), 32'(e_fault));
            chk("rdata", core_rdata, e_rdata);
            if (e_req) begin
                chk("mem_we", 32'(mem_we), 32'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_be", 32'(mem_be), 32'(e_be));
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (rst) begin
                chk("rst_mem_addr", mem_addr, 32'h0);
                chk("rst_mem_be", 32'(mem_be), 32'h0);
                chk("rst_mem_wdata", mem_wdata, 32'h0);
            end
        end
        if (core_done) begin
            last_done_cyc = cyc;
            last_mis      = core_misalign;
            last_fault    = core_fault;
        end
        if (mem_req) begin
            req_cycles++;
            last_be    = mem_be;
            last_wdata = mem_wdata;
            last_addr  = mem_addr;
            last_we    = mem_we;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic st, input logic rq, input logic dn, input logic ms, input logic ft);
        e_stall = st; e_req = rq; e_done = dn; e_mis = ms; e_fault = ft;
    endtask

    task automatic put_inputs(input txn_t t, input logic v);
        core_valid  = v;
        core_we     = t.we;
        core_funct3 = t.f3;
        core_addr   = t.addr;
        core_wdata  = t.wdata;
    endtask

    function automatic txn_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input int w, input logic [31:0] rd);
        txn_t t;
        t.we = we; t.f3 = f3; t.addr = addr; t.wdata = wd; t.w = w; t.rdata = rd;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int r;
        t.we    = 1'($urandom_range(0, 1));
        t.f3    = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) t.f3 = 3'($urandom_range(0, 2));
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.rdata = $urandom;
        r = $urandom_range(0, 9);
        t.w = (r < 8) ? $urandom_range(0, 3) : $urandom_range(13, 20);
        return t;
    endfunction

    task automatic idle_cycle();
        put_inputs(rand_txn(), 1'b0);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        set_exp(0, 0, 0, 0, 0);
        step();
    endtask

    // One transaction from its valid cycle through DONE; optionally presents
    // the next request during DONE (which must not be taken until IDLE).
    task automatic run_txn(input txn_t t, input bit b2b, input txn_t nx);
        int size, off, n;
        bit bad, fault;
        logic [3:0]  be;
        logic [31:0] lanes;
        size  = 1 << int'(t.f3[1:0]);
        off   = int'(t.addr[1:0]);
        bad   = (t.f3 == 3'd3) || (t.f3 >= 3'd6) || (t.we && t.f3 >= 3'd4) ||
                ((int'(t.addr[2:0]) % size) != 0);
        fault = !bad && (t.w >= TO);
        n     = bad ? 0 : ((t.w < TO) ? t.w + 1 : TO);
        if (t.we) be = 4'(((1 << size) - 1) << off);
        else      be = 4'hF;
        case (size)
            1:       lanes = t.wdata[7:0] * 32'h0101_0101;
            2:       lanes = t.wdata[15:0] * 32'h0001_0001;
            default: lanes = t.wdata;
        endcase

        start_cyc = cyc;
        put_inputs(t, 1'b1);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        set_exp(1, 0, 0, 0, 0);
        step();
        for (int k = 0; k < n; k++) begin
            mem_ack   = (k == t.w);
            mem_rdata = (k == t.w) ? t.rdata : $urandom;
            set_exp(1, 1, 0, 0, 0);
            e_we = t.we; e_addr = t.addr & 32'hFFFF_FFFC; e_be = be; e_wdata = lanes;
            step();
        end
        if (!bad && !fault && !t.we) e_rdata = t.rdata >> (8 * off);
        set_exp(0, 0, 1, bad, fault);
        if (b2b) put_inputs(nx, 1'b1);
        else     put_inputs(rand_txn(), 1'b0);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        $display("txn %0d: we=%0b f3=%0d addr=%h wdata=%h ack_at=%0d rdata_in=%h -> misalign=%0b fault=%0b core_rdata=%h",
                 txn_no, t.we, t.f3, t.addr, t.wdata, t.w, t.rdata, bad, fault, e_rdata);
        txn_no++;
        step();
    endtask

    initial begin
        txn_t t, nx, dummy;
        bit b2b;
        dummy = mk(0, 3'b000, 32'h0, 32'h0, 0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", 32'(core_stall), 32'h0);
        chk("reset_done", 32'(core_done), 32'h0);
        chk("reset_req", 32'(mem_req), 32'h0);
        chk("reset_rdata", core_rdata, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_be", 32'(mem_be), 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        chk("reset_flags", {30'h0, core_misalign, core_fault}, 32'h0);
        rst = 1'b0;
        set_exp(0, 0, 0, 0, 0);
        e_rdata = 32'h0;
        chk_en = 1'b1;
        step();

        // Load word
        req_cycles = 0;
        run_txn(mk(0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF), 1'b0, dummy);
        chk("lw_addr", last_addr, 32'h100);
        chk("lw_be", 32'(last_be), 32'hF);
        chk("lw_latency", 32'(last_done_cyc - start_cyc), 32'd2);
        chk("lw_rdata", core_rdata, 32'hDEAD_BEEF);
        idle_cycle();

        // Byte and unsigned half loads
        run_txn(mk(0, 3'b000, 32'h103, 32'h0, 1, 32'h80AA_BBCC), 1'b0, dummy);
        chk("lb_rdata", core_rdata, 32'h0000_0080);
        run_txn(mk(0, 3'b101, 32'h102, 32'h0, 0, 32'h80AA_BBCC), 1'b0, dummy);
        chk("lhu_rdata", core_rdata, 32'h0000_80AA);

        // Stores
        run_txn(mk(1, 3'b000, 32'h201, 32'h1234_5678, 0, 32'hFFFF_FFFF), 1'b0, dummy);
        chk("sb_be", 32'(last_be), 32'h2);
        chk("sb_wdata", last_wdata, 32'h7878_7878);
        chk("sb_we", 32'(last_we), 32'h1);
        run_txn(mk(1, 3'b001, 32'h202, 32'h1234_5678, 2, 32'hFFFF_FFFF), 1'b0, dummy);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'h5678_5678);
        chk("store_keeps_rdata", core_rdata, 32'h0000_80AA);

        // Misaligned / invalid: no bus cycle, done one cycle after valid
        req_cycles = 0;
        run_txn(mk(0, 3'b010, 32'h102, 32'h0, 0, 32'h0), 1'b0, dummy);
        chk("lw_mis_flag", 32'(last_mis), 32'h1);
        chk("lw_mis_latency", 32'(last_done_cyc - start_cyc), 32'd1);
        run_txn(mk(0, 3'b001, 32'h101, 32'h0, 0, 32'h0), 1'b0, dummy);
        chk("lh_mis_flag", 32'(last_mis), 32'h1);
        run_txn(mk(1, 3'b100, 32'h100, 32'h0, 0, 32'h0), 1'b0, dummy);
        chk("st100_mis_flag", 32'(last_mis), 32'h1);
        run_txn(mk(0, 3'b011, 32'h100, 32'h0, 0, 32'h0), 1'b0, dummy);
        chk("f3_011_mis_flag", 32'(last_mis), 32'h1);
        chk("mis_no_req", 32'(req_cycles), 32'h0);

        // Timeout, then ack in the last counted cycle
        req_cycles = 0;
        run_txn(mk(0, 3'b010, 32'h400, 32'h0, 1000, 32'h1111_2222), 1'b0, dummy);
        chk("to_req_cycles", 32'(req_cycles), 32'd16);
        chk("to_fault", 32'(last_fault), 32'h1);
        chk("to_rdata_kept", core_rdata, 32'h0000_80AA);
        req_cycles = 0;
        run_txn(mk(0, 3'b010, 32'h404, 32'h0, 15, 32'h3333_4444), 1'b0, dummy);
        chk("ack16_req_cycles", 32'(req_cycles), 32'd16);
        chk("ack16_no_fault", 32'(last_fault), 32'h0);
        chk("ack16_rdata", core_rdata, 32'h3333_4444);

        // Reset during the third REQ wait cycle, with the request still held
        t = mk(0, 3'b010, 32'h300, 32'h0, 1000, 32'h0);
        put_inputs(t, 1'b1);
        mem_ack = 1'b0;
        set_exp(1, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            set_exp(1, 1, 0, 0, 0);
            e_we = 1'b0; e_addr = 32'h300; e_be = 4'hF; e_wdata = 32'h0;
            step();
        end
        chk("rstmid_req_before", 32'(mem_req), 32'h1);
        rst = 1'b1;
        set_exp(0, 0, 0, 0, 0);
        e_rdata = 32'h0;
        #1;
        chk("rstmid_req_async", 32'(mem_req), 32'h0);
        chk("rstmid_stall", 32'(core_stall), 32'h0);
        chk("rstmid_done", 32'(core_done), 32'h0);
        step();
        rst = 1'b0;
        idle_cycle();
        run_txn(mk(0, 3'b010, 32'h500, 32'h0, 0, 32'hCAFE_F00D), 1'b0, dummy);
        chk("post_rst_lw", core_rdata, 32'hCAFE_F00D);
        idle_cycle();

        // Randomised traffic, including back-to-back requests presented during DONE
        nx = rand_txn();
        for (int i = 0; i < 300; i++) begin
            t   = nx;
            nx  = rand_txn();
            b2b = ($urandom_range(0, 3) == 0);
            run_txn(t, b2b, nx);
            if (!b2b) begin
                repeat ($urandom_range(0, 2)) idle_cycle();
            end
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
